// File: rtl/vga_timing_controller.sv
// VGA raster generator: h/v counters with region FSMs, frame strobe/counter, and a DAC
// output stage whose sync/blank are delayed to match the object-mux pipeline latency.
module vga_timing_controller #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned MUX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  frameCount,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        hSyncN,
    output logic        vSyncN,
    output logic        blankN
);

    localparam logic [10:0] H_LAST_VIS = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_LAST_FP  = 11'(H_ACTIVE + H_FP - 1);
    localparam logic [10:0] H_LAST_SYN = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST_VIS = 11'(V_ACTIVE - 1);
    localparam logic [10:0] V_LAST_FP  = 11'(V_ACTIVE + V_FP - 1);
    localparam logic [10:0] V_LAST_SYN = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {HS_VIS, HS_FP, HS_SYN, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_VIS, VS_FP, VS_SYN, VS_BP} v_state_t;

    h_state_t    h_state_q, h_state_d;
    v_state_t    v_state_q, v_state_d;
    logic [10:0] hCount_q, hCount_d;
    logic [10:0] vCount_q, vCount_d;
    logic [7:0]  frame_q, frame_d;
    logic        sof_q, sof_d;
    logic        h_wrap, v_wrap;

    logic [2:0]  raw;   // {hs, vs, vis} for the pixel currently presented
    logic [2:0]  del;   // same, aligned with the RGB arriving from the mux

    logic [7:0]  r_q, g_q, b_q;
    logic        hs_q, vs_q, bl_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_state_q <= HS_VIS;
            v_state_q <= VS_VIS;
            hCount_q  <= '0;
            vCount_q  <= '0;
            frame_q   <= '0;
            sof_q     <= 1'b0;
        end else begin
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            hCount_q  <= hCount_d;
            vCount_q  <= vCount_d;
            frame_q   <= frame_d;
            sof_q     <= sof_d;
        end
    end

    always_comb begin
        h_wrap    = (hCount_q == H_LAST);
        v_wrap    = (vCount_q == V_LAST);
        hCount_d  = h_wrap ? '0 : hCount_q + 11'd1;
        vCount_d  = vCount_q;
        frame_d   = frame_q;
        // Strobe is registered so it lands in the same clock that presents (0,0)
        sof_d     = h_wrap && v_wrap;
        h_state_d = h_state_q;
        v_state_d = v_state_q;

        if (h_wrap) begin
            vCount_d = v_wrap ? '0 : vCount_q + 11'd1;
            if (v_wrap) frame_d = frame_q + 8'd1;
        end

        case (h_state_q)
            HS_VIS: if (hCount_q == H_LAST_VIS) h_state_d = HS_FP;
            HS_FP:  if (hCount_q == H_LAST_FP)  h_state_d = HS_SYN;
            HS_SYN: if (hCount_q == H_LAST_SYN) h_state_d = HS_BP;
            HS_BP:  if (h_wrap)                 h_state_d = HS_VIS;
            default:                            h_state_d = HS_VIS;
        endcase

        if (h_wrap) begin
            case (v_state_q)
                VS_VIS: if (vCount_q == V_LAST_VIS) v_state_d = VS_FP;
                VS_FP:  if (vCount_q == V_LAST_FP)  v_state_d = VS_SYN;
                VS_SYN: if (vCount_q == V_LAST_SYN) v_state_d = VS_BP;
                VS_BP:  if (v_wrap)                 v_state_d = VS_VIS;
                default:                            v_state_d = VS_VIS;
            endcase
        end
    end

    assign raw = {h_state_q != HS_SYN, v_state_q != VS_SYN,
                  (h_state_q == HS_VIS) && (v_state_q == VS_VIS)};

    if (MUX_LATENCY == 0) begin : g_nopipe
        assign del = raw;
    end else begin : g_pipe
        logic [2:0] pipe_q [MUX_LATENCY];

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                for (int unsigned i = 0; i < MUX_LATENCY; i++) pipe_q[i] <= 3'b110;
            end else begin
                pipe_q[0] <= raw;
                for (int unsigned i = 1; i < MUX_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign del = pipe_q[MUX_LATENCY-1];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            bl_q <= 1'b0;
        end else begin
            hs_q <= del[2];
            vs_q <= del[1];
            bl_q <= del[0];
            if (del[0]) begin
                r_q <= redIn;
                g_q <= greenIn;
                b_q <= blueIn;
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
        end
    end

    assign pixelX       = hCount_q;
    assign pixelY       = vCount_q;
    assign startOfFrame = sof_q;
    assign frameCount   = frame_q;
    assign vgaR         = r_q;
    assign vgaG         = g_q;
    assign vgaB         = b_q;
    assign hSyncN       = hs_q;
    assign vSyncN       = vs_q;
    assign blankN       = bl_q;

endmodule
